// File: rtl/dso_cap_pkg.sv
// Shared types and helpers for the DSO capture engine.
// Holds the FSM state type, default geometry and ring-pointer arithmetic.
package dso_cap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        DONE
    } state_t;

    localparam int DEF_RCH_W  = 1;
    localparam int DEF_NCH    = 1 << DEF_RCH_W;
    localparam int DEF_CH_W   = 8;
    localparam int DEF_DEPTH  = 1 << 18;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
    localparam int DEF_DECI_W = 16;

    function automatic int rch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Ring pointer add; aw = 32 gives a full-width mask.
    function automatic logic [31:0] ptr_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          aw
    );
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/dso_deci_cnt.sv
// Decimation counter: one strobe every deci+1 clocks.
// Synchronous clear restarts the count so a new capture is phase-aligned.
module dso_deci_cnt #(
    parameter int DECI_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DECI_W-1:0] deci,
    output logic              stb
);

    logic [DECI_W-1:0] cnt;

    // >= keeps the count bounded if deci is lowered mid-interval
    assign stb = (cnt >= deci);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (stb) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dso_capture.sv
// Acquisition engine: decimated ring-buffer capture into SRAM with
// pre/post trigger windows and write-priority sample readback.
module dso_capture
    import dso_cap_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int CH_W   = DEF_CH_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DECI_W = DEF_DECI_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DECI_W-1:0]     deci,
    input  logic [ADDR_W-1:0]     pre_len,
    input  logic [ADDR_W-1:0]     post_len,
    input  logic                  trig,
    input  logic [NCH*CH_W-1:0]   din,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [NCH*CH_W-1:0]   mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [NCH*CH_W-1:0]   mem_rdata,
    input  logic                  rd_req,
    input  logic [rch_w(NCH)-1:0] rd_ch,
    input  logic [7:0]            rd_step,
    output logic [CH_W-1:0]       rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  trig_seen,
    output logic                  done,
    output logic [ADDR_W-1:0]     trig_addr
);

    localparam int RCH_W = rch_w(NCH);

    state_t state, state_n;

    logic              stb;
    logic              trig_q;
    logic              edge_hit;
    logic              wr;
    logic              rd;
    logic              pend;
    logic              pre_hit;
    logic              post_hit;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] post_eff;
    logic [ADDR_W-1:0] pre_eff;
    logic [ADDR_W-1:0] trig_base;
    logic [ADDR_W:0]   len_sum;
    logic [7:0]        step_eff;
    logic [RCH_W-1:0]  ch_q;
    logic [CH_W-1:0]   ch_sel;

    dso_deci_cnt #(
        .DECI_W(DECI_W)
    ) u_deci (
        .clk (clk),
        .rst (rst),
        .clr (arm),
        .deci(deci),
        .stb (stb)
    );

    assign busy     = (state == PRE) || (state == WAIT) || (state == POST);
    assign wr       = busy && stb && !rst;
    assign rd       = pend && !wr && !abort && !rst;
    assign edge_hit = stb && trig && !trig_q;

    assign post_eff = (post_len == '0) ? ADDR_W'(1) : post_len;
    assign len_sum  = {1'b0, pre_len} + {1'b0, post_eff};
    // Overflowing windows give up pre samples; ~post_eff == depth-1-post
    assign pre_eff  = len_sum[ADDR_W] ? ~post_eff : pre_len;
    assign step_eff = (rd_step == 8'd0) ? 8'd1 : rd_step;

    assign pre_hit  = (cnt >= pre_eff) || (stb && (cnt + 1'b1) >= pre_eff);
    assign post_hit = stb && ((cnt + 1'b1) >= post_eff);
    // A one-sample post window finishes straight from WAIT
    assign trig_base = (state == WAIT) ? wptr : trig_addr;

    assign mem_we    = wr;
    assign mem_re    = rd;
    assign mem_addr  = wr ? wptr : rptr;
    assign mem_wdata = wr ? din : '0;

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(ch_q) == i) begin
                ch_sel = mem_rdata[i*CH_W +: CH_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else if (arm) begin
            state_n = PRE;
        end else begin
            unique case (state)
                PRE:     if (pre_hit) state_n = WAIT;
                WAIT:    if (edge_hit) state_n = (post_eff == ADDR_W'(1)) ? DONE : POST;
                POST:    if (post_hit) state_n = DONE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q    <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            trig_seen <= 1'b0;
            trig_addr <= '0;
            pend      <= 1'b0;
            ch_q      <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (stb) trig_q <= trig;
            if (wr) wptr <= ADDR_W'(ptr_add(32'(wptr), 32'd1, ADDR_W));

            rd_valid <= rd;
            if (rd) begin
                rd_data <= ch_sel;
                rptr    <= ADDR_W'(ptr_add(32'(rptr), 32'(step_eff), ADDR_W));
            end

            if (abort) begin
                pend <= 1'b0;
            end else if (rd) begin
                pend <= 1'b0;
            end else if (rd_req && !pend) begin
                pend <= 1'b1;
                ch_q <= rd_ch;
            end

            if (abort) begin
                done <= 1'b0;
            end else if (arm) begin
                cnt       <= '0;
                done      <= 1'b0;
                trig_seen <= 1'b0;
            end else begin
                unique case (state)
                    PRE:  if (stb) cnt <= cnt + 1'b1;
                    POST: if (stb) cnt <= cnt + 1'b1;
                    WAIT: begin
                        if (edge_hit) begin
                            cnt       <= ADDR_W'(1);
                            trig_seen <= 1'b1;
                            trig_addr <= wptr;
                        end
                    end
                    default: cnt <= cnt;
                endcase
                if (state_n == DONE && state != DONE) begin
                    done <= 1'b1;
                    rptr <= ADDR_W'(ptr_add(32'(trig_base),
                                            32'(~pre_eff) + 32'd1, ADDR_W));
                end
            end
        end
    end

endmodule

// File: tb/tb_dso_capture.sv
// Bench for dso_capture on a 16-word ring: sample-level reference model
// feeding write/read scoreboards checked by an independent monitor.
module tb_dso_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        abort;
    logic [7:0]  deci;
    logic [3:0]  pre_len;
    logic [3:0]  post_len;
    logic        trig;
    logic [15:0] din;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        rd_req;
    logic [0:0]  rd_ch;
    logic [7:0]  rd_step;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        trig_seen;
    logic        done;
    logic [3:0]  trig_addr;

    dso_capture #(
        .NCH(2), .CH_W(8), .ADDR_W(4), .DECI_W(8)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .deci(deci),
        .pre_len(pre_len), .post_len(post_len), .trig(trig), .din(din),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .rd_req(rd_req),
        .rd_ch(rd_ch), .rd_step(rd_step), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .trig_seen(trig_seen),
        .done(done), .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    // SRAM model
    logic [15:0] sram [16];
    always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_wdata;
    assign mem_rdata = sram[mem_addr];

    // Reference state
    logic [15:0] ref_mem [16];
    int          w_m = 0;
    int          r_m = 0;
    logic [19:0] wq [$];
    logic [3:0]  raq [$];
    logic [7:0]  rdq [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_rv = 0;
    logic        prev_re = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] e;
        if (rst) begin
            prev_re = 1'b0;
        end else begin
            if (mem_we || mem_re) chk("we_re_exclusive", 32'(mem_we & mem_re), 0);
            if (mem_we) begin
                n_chk++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h at %0t",
                             mem_addr, mem_wdata, $time);
                end else begin
                    n_chk--;
                    e = wq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[19:16]));
                    chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
                end
            end
            if (mem_re) begin
                n_chk++;
                if (raq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: addr %0h at %0t", mem_addr, $time);
                end else begin
                    n_chk--;
                    chk("rd_addr", 32'(mem_addr), 32'(raq.pop_front()));
                end
            end
            if (rd_valid || prev_re) chk("rd_valid_timing", 32'(rd_valid), 32'(prev_re));
            if (rd_valid) begin
                n_rv++;
                n_chk++;
                if (rdq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rd_valid: data %0h at %0t", rd_data, $time);
                end else begin
                    n_chk--;
                    chk("rd_data", 32'(rd_data), 32'(rdq.pop_front()));
                end
            end
            prev_re = mem_re;
        end
    end

    task automatic push_read(input int ch, input int step);
        raq.push_back(4'(r_m));
        rdq.push_back(ch != 0 ? ref_mem[r_m][15:8] : ref_mem[r_m][7:0]);
        r_m = (r_m + ((step == 0) ? 1 : step)) % 16;
    endtask

    // One capture described in sample units; abort_at > 0 means no trigger.
    task automatic run_capture(input int d, input int pre, input int post,
                               input int extra, input bit glitch,
                               input int abort_at, input int rdreq_at,
                               output int p, output int q);
        int  ign, t_smp, total, m, ws;
        bit  tl [64];
        q     = (post == 0) ? 1 : post;
        p     = (pre + q > 15) ? 15 - q : pre;
        ign   = (p > 0) ? p : ((d == 0) ? 1 : 0);
        t_smp = (abort_at > 0) ? 63 : ign + extra;
        for (int s = 0; s < 64; s++) begin
            if (s < ign - 1) tl[s] = 1'($urandom_range(0, 1));
            else if (s < t_smp) tl[s] = 1'b0;
            else if (s == t_smp) tl[s] = 1'b1;
            else tl[s] = 1'($urandom_range(0, 1));
        end
        deci = 8'(d); pre_len = 4'(pre); post_len = 4'(post); trig = 1'b0;
        repeat (2 * (d + 1) + 1) @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        ws    = w_m;
        total = (abort_at > 0) ? abort_at : (t_smp + q) * (d + 1);
        for (int j = 1; j <= total; j++) begin
            m    = (j - 1) / (d + 1);
            din  = 16'($urandom);
            trig = tl[m];
            if (glitch && d >= 1 && m >= ign && m < t_smp && (j % (d + 1)) == 1)
                trig = 1'b1;
            if (abort_at > 0 && j == abort_at) abort = 1'b1;
            if (j == rdreq_at) begin
                rd_req = 1'b1;
                if (d > 0) push_read(int'(rd_ch), int'(rd_step));
            end
            if ((j % (d + 1)) == 0) begin
                wq.push_back({4'(w_m), din});
                ref_mem[w_m] = din;
                w_m = (w_m + 1) % 16;
            end
            @(posedge clk);
            #1;
            abort = 1'b0; rd_req = 1'b0; trig = 1'b0;
        end
        if (abort_at > 0) begin
            chk("abort_busy", 32'(busy), 0);
            chk("abort_done", 32'(done), 0);
        end else begin
            chk("done", 32'(done), 1);
            chk("busy_done", 32'(busy), 0);
            chk("trig_seen", 32'(trig_seen), 1);
            chk("trig_addr", 32'(trig_addr), 32'((ws + t_smp) % 16));
            r_m = (ws + t_smp + 16 - p) % 16;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reads(input int n, input int step, input int ch);
        int base, k;
        rd_step = 8'(step); rd_ch = 1'(ch);
        for (int i = 0; i < n; i++) begin
            push_read(ch, step);
            base = n_rv;
            rd_req = 1'b1;
            @(posedge clk);
            #1 rd_req = 1'b0;
            k = 0;
            while (n_rv == base && k < 20) begin
                @(posedge clk);
                #1 k++;
            end
            if (n_rv == base) chk("read_timeout", 32'(k), 0);
        end
    endtask

    initial begin
        int p, q, n;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; deci = '0; pre_len = '0;
        post_len = '0; trig = 1'b0; din = '0; rd_req = 1'b0; rd_ch = '0;
        rd_step = 8'd1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_trig_seen", 32'(trig_seen), 0);
        chk("rst_trig_addr", 32'(trig_addr), 0);

        // Basic capture: trigger on sample 10, reads 6..12 upper byte
        run_capture(0, 4, 3, 6, 1'b0, 0, 0, p, q);
        do_reads(7, 1, 1);
        // deci=3 with short trig pulses between strobes; ends with wptr=14
        run_capture(3, 4, 3, 10, 1'b1, 0, 0, p, q);
        // Wrap: trigger at 3, readback from 14 across 15->0
        run_capture(0, 5, 3, 0, 1'b0, 0, 0, p, q);
        do_reads(4, 1, 0);
        // Read parked behind continuous writes, dropped by abort
        run_capture(0, 2, 3, 0, 1'b0, 8, 4, p, q);
        // Read slotted into a non-write clock
        run_capture(1, 2, 3, 0, 1'b0, 8, 6, p, q);
        // pre=0/post=0 and saturated windows
        run_capture(0, 0, 0, 0, 1'b0, 0, 0, p, q);
        do_reads(2, 0, 1);
        run_capture(2, 14, 5, 1, 1'b1, 0, 0, p, q);
        do_reads(15, 1, 0);

        for (int it = 0; it < 8; it++) begin
            int d;
            d = $urandom_range(0, 3);
            run_capture(d, $urandom_range(0, 12), $urandom_range(0, 12),
                        $urandom_range(0, 3), (d > 0) && ($urandom_range(0, 1) == 1),
                        0, 0, p, q);
            n = $urandom_range(1, p + q);
            do_reads(n, $urandom_range(0, 3), $urandom_range(0, 1));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("wq_drained", 32'(wq.size()), 0);
        chk("raq_drained", 32'(raq.size()), 0);
        chk("rdq_drained", 32'(rdq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
